// File: rtl/uart_pkg.sv
// Shared definitions for the UART core (transmitter and receiver).
// Holds the FSM state encoding, parity modes, frame width and the parity helper.
package uart_pkg;

    localparam int DATA_BITS = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Even parity is the plain XOR of the data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input int mode);
        return (^data) ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: valid/ready input with one-byte holding register,
// LSB-first framing with optional parity and 1 or 2 stop bits, timed by an external 1x baud strobe.
module uart_tx
    import uart_pkg::*;
#(
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_txpulse,
    output logic       o_txd,
    output logic       o_txsync,
    output logic       o_busy
);

    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic       EXTRA_STOP = (STOP_BITS == 2);

    uart_state_t state_reg, state_next;
    logic [7:0]  sh_reg, sh_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic        stop_cnt_reg, stop_cnt_next;
    logic        par_reg, par_next;
    logic [7:0]  hold_data_reg, hold_data_next;
    logic        hold_valid_reg, hold_valid_next;
    logic        txd_reg, txd_next;
    logic        txsync_reg, txsync_next;
    logic        ready_reg;
    logic        load;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_IDLE;
            sh_reg         <= '0;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= 1'b0;
            par_reg        <= 1'b0;
            hold_data_reg  <= '0;
            hold_valid_reg <= 1'b0;
            txd_reg        <= 1'b1;
            txsync_reg     <= 1'b0;
            ready_reg      <= 1'b1;
        end else begin
            state_reg      <= state_next;
            sh_reg         <= sh_next;
            bit_cnt_reg    <= bit_cnt_next;
            stop_cnt_reg   <= stop_cnt_next;
            par_reg        <= par_next;
            hold_data_reg  <= hold_data_next;
            hold_valid_reg <= hold_valid_next;
            txd_reg        <= txd_next;
            txsync_reg     <= txsync_next;
            ready_reg      <= !hold_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        sh_next         = sh_reg;
        bit_cnt_next    = bit_cnt_reg;
        stop_cnt_next   = stop_cnt_reg;
        par_next        = par_reg;
        hold_data_next  = hold_data_reg;
        hold_valid_next = hold_valid_reg;
        txd_next        = txd_reg;
        txsync_next     = 1'b0;
        load            = 1'b0;

        // ready_reg mirrors !hold_valid_reg, so an accept never collides with a load.
        if (i_valid && ready_reg) begin
            hold_valid_next = 1'b1;
            hold_data_next  = i_data;
        end

        case (state_reg)
            ST_IDLE: begin
                txd_next = 1'b1;
                if (hold_valid_reg) begin
                    load        = 1'b1;
                    txsync_next = 1'b1;
                end
            end
            ST_START: begin
                if (i_txpulse) begin
                    txd_next     = sh_reg[0];
                    bit_cnt_next = '0;
                    state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (i_txpulse) begin
                    if (bit_cnt_reg == LAST_BIT) begin
                        stop_cnt_next = EXTRA_STOP;
                        if (PARITY != PAR_NONE) begin
                            txd_next   = par_reg;
                            state_next = ST_PARITY;
                        end else begin
                            txd_next   = 1'b1;
                            state_next = ST_STOP;
                        end
                    end else begin
                        sh_next      = sh_reg >> 1;
                        txd_next     = sh_reg[1];
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (i_txpulse) begin
                    txd_next   = 1'b1;
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (i_txpulse) begin
                    if (stop_cnt_reg) begin
                        stop_cnt_next = 1'b0;
                    end else if (hold_valid_reg) begin
                        // Back-to-back: baud generator is already aligned, no resync.
                        load = 1'b1;
                    end else begin
                        txd_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                txd_next   = 1'b1;
                state_next = ST_IDLE;
            end
        endcase

        if (load) begin
            sh_next         = hold_data_reg;
            par_next        = parity_bit(hold_data_reg, PARITY);
            hold_valid_next = 1'b0;
            txd_next        = 1'b0;
            state_next      = ST_START;
        end
    end

    assign o_ready  = ready_reg;
    assign o_txd    = txd_reg;
    assign o_txsync = txsync_reg;
    assign o_busy   = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four instances (none/1, even/1, odd/1, none/2) against a frame-level model.
// Each instance has its own baud strobe generator that restarts on o_txsync and logs the line once per bit.
module tb_uart_tx;

    logic       clk;
    logic       rst   [4];
    logic       valid [4];
    logic [7:0] data  [4];

    logic [3:0] d_txd, d_ready, d_sync, d_busy;
    logic [3:0] mm_txd, mm_ready, mm_sync, mm_busy, mm_active, mm_hold;
    logic [127:0] lb [4];
    int           ln [4];
    int           ns [4];
    int           nf [4];

    int tests;
    int fails;
    bit check_en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Serial frame as a bit list: index 0 is the start bit, stop bits fill the top.
    function automatic logic [11:0] frame_of(input logic [7:0] b, input int par);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (par != 0) f[9] = (^b) ^ (par == 2);
        return f;
    endfunction

    function automatic int frame_len(input int par, input int stops);
        return 9 + ((par != 0) ? 1 : 0) + stops;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_inst
            localparam int PAR   = (gi == 1) ? 1 : ((gi == 2) ? 2 : 0);
            localparam int STOPS = (gi == 3) ? 2 : 1;

            logic         txpulse  = 1'b0;
            int           baud_cnt = 0;
            logic [127:0] log_bits = '0;
            int           log_n    = 0;
            int           n_sync   = 0;
            int           n_fall   = 0;
            logic         busy_q   = 1'b0;

            logic         m_active = 1'b0;
            logic         m_hold   = 1'b0;
            logic         m_sync   = 1'b0;
            logic [7:0]   m_hdata  = '0;
            logic [11:0]  m_bits   = '1;
            int           m_idx    = 0;
            int           m_len    = 0;

            uart_tx #(.PARITY(PAR), .STOP_BITS(STOPS)) u_dut (
                .i_clk     (clk),
                .i_rst     (rst[gi]),
                .i_data    (data[gi]),
                .i_valid   (valid[gi]),
                .o_ready   (d_ready[gi]),
                .i_txpulse (txpulse),
                .o_txd     (d_txd[gi]),
                .o_txsync  (d_sync[gi]),
                .o_busy    (d_busy[gi])
            );

            // Frame-level model: a frame is a bit list walked one entry per strobe.
            always @(posedge clk) begin
                logic act, hold, load, sync;
                int   idx;
                act  = m_active;
                hold = m_hold;
                idx  = m_idx;
                load = 1'b0;
                sync = 1'b0;
                if (rst[gi]) begin
                    act  = 1'b0;
                    hold = 1'b0;
                    idx  = 0;
                end else begin
                    if (act) begin
                        if (txpulse) begin
                            idx = idx + 1;
                            if (idx == m_len) begin
                                if (m_hold) load = 1'b1;
                                else        act  = 1'b0;
                            end
                        end
                    end else if (m_hold) begin
                        load = 1'b1;
                        sync = 1'b1;
                    end
                    if (load) begin
                        m_bits <= frame_of(m_hdata, PAR);
                        m_len  <= frame_len(PAR, STOPS);
                        act    = 1'b1;
                        idx    = 0;
                        hold   = 1'b0;
                    end
                    if (valid[gi] && !m_hold) begin
                        hold = 1'b1;
                        m_hdata <= data[gi];
                    end
                end
                m_active <= act;
                m_hold   <= hold;
                m_idx    <= idx;
                m_sync   <= sync;
            end

            // Baud generator (16 clocks per bit, restarted by o_txsync) and per-bit line logger.
            always @(negedge clk) begin
                int   nc;
                logic nxt;
                nc  = d_sync[gi] ? 0 : ((baud_cnt == 15) ? 0 : baud_cnt + 1);
                nxt = (nc == 15);
                baud_cnt <= nc;
                txpulse  <= nxt;
                if (nxt && d_busy[gi] && log_n < 128) begin
                    log_bits[log_n[6:0]] <= d_txd[gi];
                    log_n <= log_n + 1;
                end
                if (d_sync[gi]) n_sync <= n_sync + 1;
                if (busy_q && !d_busy[gi]) n_fall <= n_fall + 1;
                busy_q <= d_busy[gi];
            end

            assign mm_txd[gi]    = m_active ? m_bits[m_idx[3:0]] : 1'b1;
            assign mm_ready[gi]  = !m_hold;
            assign mm_sync[gi]   = m_sync;
            assign mm_busy[gi]   = m_active;
            assign mm_active[gi] = m_active;
            assign mm_hold[gi]   = m_hold;
            assign lb[gi]        = log_bits;
            assign ln[gi]        = log_n;
            assign ns[gi]        = n_sync;
            assign nf[gi]        = n_fall;
        end
    endgenerate

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, inst, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int inst);
        tests++;
        fails++;
        $display("FAIL %s inst%0d: timed out waiting (t=%0t)", name, inst, $time);
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (check_en) begin
                for (int i = 0; i < 4; i++) begin
                    check("txd",   i, d_txd[i],   mm_txd[i]);
                    check("ready", i, d_ready[i], mm_ready[i]);
                    check("sync",  i, d_sync[i],  mm_sync[i]);
                    check("busy",  i, d_busy[i],  mm_busy[i]);
                end
            end
        end
    endtask

    // Present a byte and return at the negedge after the handshake edge, leaving i_valid high.
    task automatic send(input int inst, input logic [7:0] b);
        valid[inst] = 1'b1;
        data[inst]  = b;
        for (int k = 0; k < 4000; k++) begin
            if (mm_ready[inst]) begin
                @(negedge clk);
                $display("[TB] inst%0d sent byte 0x%02h", inst, b);
                return;
            end
            @(negedge clk);
        end
        timeout("send", inst);
    endtask

    task automatic wait_idle(input int inst);
        for (int k = 0; k < 4000; k++) begin
            if (!mm_active[inst] && !mm_hold[inst]) begin
                repeat (2) @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        timeout("wait_idle", inst);
    endtask

    function automatic logic [31:0] log_slice(input int inst, input int base);
        logic [127:0] t;
        t = lb[inst] >> base;
        return t[31:0];
    endfunction

    initial begin
        int          base, s0, f0, n0, waited;
        logic [7:0]  saved;
        logic [31:0] sl;
        logic [11:0] fr;

        tests    = 0;
        fails    = 0;
        check_en = 1'b0;
        saved    = '0;
        for (int i = 0; i < 4; i++) begin
            rst[i]   = 1'b1;
            valid[i] = 1'b0;
            data[i]  = '0;
        end
        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        check_en = 1'b1;
        check("rst_txd",   0, d_txd[0],   1);
        check("rst_ready", 0, d_ready[0], 1);
        check("rst_busy",  0, d_busy[0],  0);
        check("rst_sync",  0, d_sync[0],  0);
        for (int i = 0; i < 4; i++) rst[i] = 1'b0;
        repeat (2) @(negedge clk);

        // Pin the frame builder to hand-derived bit lists.
        check("pin_frame_55",   0, frame_of(8'h55, 0), 12'hEAA);
        check("pin_frame_a3e",  1, frame_of(8'hA3, 1), 12'hD46);
        check("pin_frame_a3o",  2, frame_of(8'hA3, 2), 12'hF46);
        check("pin_frame_ff",   3, frame_of(8'hFF, 0), 12'hFFE);
        check("pin_len_n1",     0, frame_len(0, 1), 10);
        check("pin_len_p1",     1, frame_len(1, 1), 11);
        check("pin_len_n2",     3, frame_len(0, 2), 11);

        // 0x55, no parity, one stop bit.
        base = ln[0]; s0 = ns[0];
        send(0, 8'h55);
        valid[0] = 1'b0;
        wait_idle(0);
        sl = log_slice(0, base);
        check("t55_bits",  0, sl[9:0], 10'h2AA);
        check("t55_count", 0, ln[0] - base, 10);
        check("t55_sync",  0, ns[0] - s0, 1);

        // 0xA3 with even then odd parity.
        base = ln[1];
        send(1, 8'hA3);
        valid[1] = 1'b0;
        wait_idle(1);
        sl = log_slice(1, base);
        check("ta3_even_bits",  1, sl[10:0], 11'h546);
        check("ta3_even_count", 1, ln[1] - base, 11);
        base = ln[2];
        send(2, 8'hA3);
        valid[2] = 1'b0;
        wait_idle(2);
        sl = log_slice(2, base);
        check("ta3_odd_bits",   2, sl[10:0], 11'h746);

        // 0x01 then 0x80 with i_valid held: no idle gap, a single resync.
        base = ln[0]; s0 = ns[0]; f0 = nf[0];
        send(0, 8'h01);
        send(0, 8'h80);
        check("b2b_accept_busy", 0, d_busy[0], 1);
        valid[0] = 1'b0;
        wait_idle(0);
        sl = log_slice(0, base);
        check("b2b_bits",  0, sl[19:0], 20'hC0202);
        check("b2b_sync",  0, ns[0] - s0, 1);
        check("b2b_gaps",  0, nf[0] - f0, 1);

        // 0xFF with two stop bits.
        base = ln[3];
        send(3, 8'hFF);
        valid[3] = 1'b0;
        wait_idle(3);
        sl = log_slice(3, base);
        check("tff_bits",  3, sl[10:0], 11'h7FE);
        check("tff_count", 3, ln[3] - base, 11);

        // Held off while the holding register is full, i_data changing every cycle.
        base = ln[0];
        send(0, 8'h11);
        send(0, 8'h22);
        waited = 0;
        for (int k = 0; k < 4000; k++) begin
            data[0] = 8'($urandom);
            if (mm_ready[0]) begin
                saved = data[0];
                @(negedge clk);
                break;
            end
            waited++;
            @(negedge clk);
        end
        valid[0] = 1'b0;
        $display("[TB] inst0 sent byte 0x%02h after %0d held-off cycles", saved, waited);
        check("holdoff_long", 0, (waited >= 100) ? 1 : 0, 1);
        wait_idle(0);
        sl = log_slice(0, base);
        fr = frame_of(saved, 0);
        check("holdoff_f1", 0, sl[9:0],   10'h222);
        check("holdoff_f2", 0, sl[19:10], 10'h244);
        check("holdoff_f3", 0, sl[29:20], {22'd0, fr[9:0]});

        // Reset during data bit 4, with a second byte waiting in the holding register.
        base = ln[0];
        send(0, 8'h0F);
        send(0, 8'h33);
        valid[0] = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (ln[0] - base >= 5) break;
            if (k == 1999) timeout("reach_bit4", 0);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("abort_txd",   0, d_txd[0],   1);
        check("abort_ready", 0, d_ready[0], 1);
        check("abort_busy",  0, d_busy[0],  0);
        n0 = ln[0]; s0 = ns[0];
        repeat (60) @(negedge clk);
        check("abort_nobits", 0, ln[0] - n0, 0);
        check("abort_nosync", 0, ns[0] - s0, 0);
        base = ln[0];
        send(0, 8'h5A);
        valid[0] = 1'b0;
        wait_idle(0);
        sl = log_slice(0, base);
        check("after_abort_bits", 0, sl[9:0], 10'h2B4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
